// File: rtl/debounce_pkg.sv
// Shared helpers for the multi-channel switch debouncer.
// Counter widths are sized so that a counter can hold its own limit value.
package debounce_pkg;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch channel: 2-flop synchroniser, stability counter,
// registered level with rise/fall pulses and a once-per-press long-hold pulse.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned HOLD_LIMIT     = 12500000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_bouncy,
    output logic o_debounced,
    output logic o_rise,
    output logic o_fall,
    output logic o_long
);

    localparam int unsigned CntW  = cnt_width(DEBOUNCE_LIMIT);
    localparam int unsigned HcntW = cnt_width(HOLD_LIMIT);

    localparam logic [CntW-1:0]  CntLast  = CntW'(DEBOUNCE_LIMIT - 1);
    localparam logic [HcntW-1:0] HoldMax  = HcntW'(HOLD_LIMIT);
    localparam logic [HcntW-1:0] HoldLast = HcntW'(HOLD_LIMIT - 1);

    logic [1:0]       sync_q;
    logic             s;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [HcntW-1:0] hcnt_q, hcnt_d;
    logic             deb_q, deb_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             long_q, long_d;

    assign s = sync_q[1];

    always_comb begin
        deb_d  = deb_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s != deb_q) begin
            if (cnt_q == CntLast) begin
                deb_d  = s;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Clearing on the falling edge itself keeps o_long and o_fall mutually exclusive.
    always_comb begin
        hcnt_d = hcnt_q;
        long_d = 1'b0;
        if (!deb_q || fall_d) begin
            hcnt_d = '0;
        end else if (hcnt_q != HoldMax) begin
            hcnt_d = hcnt_q + 1'b1;
            long_d = (hcnt_q == HoldLast);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            hcnt_q <= '0;
            deb_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            long_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], i_bouncy};
            cnt_q  <= cnt_d;
            hcnt_q <= hcnt_d;
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            long_q <= long_d;
        end
    end

    assign o_debounced = deb_q;
    assign o_rise      = rise_q;
    assign o_fall      = fall_q;
    assign o_long      = long_q;

endmodule

// File: rtl/debounce_multi_filter.sv
// N-channel switch debouncer; each channel is an independent debounce_channel.
module debounce_multi_filter
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned HOLD_LIMIT     = 12500000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NUM_CH-1:0] i_bouncy,
    output logic [NUM_CH-1:0] o_debounced,
    output logic [NUM_CH-1:0] o_rise,
    output logic [NUM_CH-1:0] o_fall,
    output logic [NUM_CH-1:0] o_long
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
            .HOLD_LIMIT    (HOLD_LIMIT)
        ) u_ch (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_bouncy   (i_bouncy[g]),
            .o_debounced(o_debounced[g]),
            .o_rise     (o_rise[g]),
            .o_fall     (o_fall[g]),
            .o_long     (o_long[g])
        );
    end

endmodule

// File: tb/tb_debounce_multi_filter.sv
// Directed bench for debounce_multi_filter with NUM_CH=2, DEBOUNCE_LIMIT=4, HOLD_LIMIT=8.
module tb_debounce_multi_filter;

    logic       clk;
    logic       rst;
    logic [1:0] bouncy;
    logic [1:0] deb;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] lng;

    int checks = 0;
    int errors = 0;

    debounce_multi_filter #(
        .NUM_CH        (2),
        .DEBOUNCE_LIMIT(4),
        .HOLD_LIMIT    (8)
    ) u_dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_bouncy   (bouncy),
        .o_debounced(deb),
        .o_rise     (rise),
        .o_fall     (fall),
        .o_long     (lng)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n_long, n_rise, n_fall, first_rise, first_fall;

        rst    = 1'b1;
        bouncy = 2'b00;
        tick(2);
        check("rst_deb", 32'(deb), 32'h0);
        check("rst_rise", 32'(rise), 32'h0);
        check("rst_fall", 32'(fall), 32'h0);
        check("rst_long", 32'(lng), 32'h0);
        rst = 1'b0;

        // Clean press: change after edge 0, accepted on edge 6.
        bouncy = 2'b01;
        tick(5);
        check("t1_deb_e5", 32'(deb), 32'h0);
        check("t1_rise_e5", 32'(rise), 32'h0);
        tick();
        check("t1_deb_e6", 32'(deb), 32'h1);
        check("t1_rise_e6", 32'(rise), 32'h1);
        tick();
        check("t1_rise_e7", 32'(rise), 32'h0);

        // Long press: o_long exactly 8 cycles after o_rise, then never again.
        tick(6);
        check("t3_long_r7", 32'(lng), 32'h0);
        tick();
        check("t3_long_r8", 32'(lng), 32'h1);
        n_long = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (lng[0]) n_long++;
        end
        check("t3_no_second_long", 32'(n_long), 32'h0);

        // Release after a long press.
        bouncy = 2'b00;
        tick(5);
        check("rel_deb_e5", 32'(deb), 32'h1);
        tick();
        check("rel_deb_e6", 32'(deb), 32'h0);
        check("rel_fall_e6", 32'(fall), 32'h1);
        tick();
        check("rel_fall_e7", 32'(fall), 32'h0);

        // Glitch: 1 for 3 cycles, 0 for 1, then 1; accept 6 cycles after final rise.
        bouncy = 2'b01;
        tick(3);
        bouncy = 2'b00;
        tick();
        bouncy = 2'b01;
        n_rise     = 0;
        first_rise = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (rise[0]) begin
                n_rise++;
                if (first_rise == 0) first_rise = i;
            end
        end
        check("t2_rise_at", 32'(first_rise), 32'd6);
        check("t2_rise_count", 32'(n_rise), 32'd1);
        check("t2_deb", 32'(deb), 32'h1);

        // Short press: the fall lands where hcnt would reach the limit; no o_long.
        bouncy = 2'b00;
        n_long     = 0;
        n_fall     = 0;
        first_fall = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (lng[0]) n_long++;
            if (fall[0]) begin
                n_fall++;
                if (first_fall == 0) first_fall = i;
            end
        end
        check("t4_fall_at", 32'(first_fall), 32'd6);
        check("t4_fall_count", 32'(n_fall), 32'd1);
        check("t4_no_long", 32'(n_long), 32'h0);
        check("t4_deb", 32'(deb), 32'h0);

        // Multichannel: simultaneous rise, ch1 drops 10 cycles later.
        bouncy = 2'b11;
        tick(6);
        check("t5_rise_both", 32'(rise), 32'h3);
        check("t5_deb_both", 32'(deb), 32'h3);
        tick(4);
        bouncy = 2'b01;
        tick(4);
        check("t5_long_both", 32'(lng), 32'h3);
        tick();
        check("t5_long_once", 32'(lng), 32'h0);
        tick();
        check("t5_fall_ch1", 32'(fall), 32'h2);
        check("t5_deb_ch0", 32'(deb), 32'h1);
        check("t5_rise_none", 32'(rise), 32'h0);

        // Mid-count reset while ch1 is high and ch0 is counting.
        bouncy = 2'b10;
        tick(6);
        check("t6_pre_fall", 32'(fall), 32'h1);
        check("t6_pre_rise", 32'(rise), 32'h2);
        check("t6_pre_deb", 32'(deb), 32'h2);
        tick(2);
        bouncy = 2'b11;
        tick(4);
        rst = 1'b1;
        tick();
        check("t6_rst_deb", 32'(deb), 32'h0);
        check("t6_rst_rise", 32'(rise), 32'h0);
        check("t6_rst_fall", 32'(fall), 32'h0);
        check("t6_rst_long", 32'(lng), 32'h0);
        rst = 1'b0;
        tick(5);
        check("t6_deb_e5", 32'(deb), 32'h0);
        tick();
        check("t6_rise_e6", 32'(rise), 32'h3);
        check("t6_deb_e6", 32'(deb), 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
